// File: rtl/vga_window_scanner.sv
// Programmable VGA timing generator with a rectangular frame-buffer window; read data is realigned with sync/DE.
// Optional build macro VGA_SCALE2X_EN: every source pixel covers a 2x2 screen block.
module vga_window_scanner #(
   parameter int          H_ACTIVE  = 640,
   parameter int          H_FP      = 16,
   parameter int          H_SYNC    = 96,
   parameter int          H_BP      = 48,
   parameter int          V_ACTIVE  = 480,
   parameter int          V_FP      = 10,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 33,
   parameter int          WIN_X     = 170,
   parameter int          WIN_Y     = 90,
   parameter int          WIN_W     = 300,
   parameter int          WIN_H     = 300,
   parameter int          ADDR_W    = 24,
   parameter int unsigned BASE_ADDR = 376,
   parameter int          RD_LAT    = 2,
   parameter bit          BORDER_EN = 1'b1,
   parameter logic [7:0]  BG_COLOR  = 8'h00
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_de,
   output logic [7:0]        vga_r,
   output logic [7:0]        vga_g,
   output logic [7:0]        vga_b,
   output logic [11:0]       pix_x,
   output logic [11:0]       pix_y,
   output logic              frame_start
);

`ifdef VGA_SCALE2X_EN
   localparam int SCALE = 2;
`else
   localparam int SCALE = 1;
`endif

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int WIN_FW  = WIN_W * SCALE;
   localparam int WIN_FH  = WIN_H * SCALE;

   localparam logic [11:0] L_H_LAST  = 12'(H_TOTAL - 1);
   localparam logic [11:0] L_V_LAST  = 12'(V_TOTAL - 1);
   localparam logic [11:0] L_HA      = 12'(H_ACTIVE);
   localparam logic [11:0] L_VA      = 12'(V_ACTIVE);
   localparam logic [11:0] L_HA_LAST = 12'(H_ACTIVE - 1);
   localparam logic [11:0] L_VA_LAST = 12'(V_ACTIVE - 1);
   localparam logic [11:0] L_HS_BEG  = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] L_HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] L_VS_BEG  = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] L_VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] L_WX0     = 12'(WIN_X);
   localparam logic [11:0] L_WX1     = 12'(WIN_X + WIN_FW);
   localparam logic [11:0] L_WY0     = 12'(WIN_Y);
   localparam logic [11:0] L_WY1     = 12'(WIN_Y + WIN_FH);
   localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);

   if (WIN_X + WIN_FW > H_ACTIVE) begin : g_chk_win_x
      $error("vga_window_scanner: window exceeds active width");
   end
   if (WIN_Y + WIN_FH > V_ACTIVE) begin : g_chk_win_y
      $error("vga_window_scanner: window exceeds active height");
   end
   if (RD_LAT < 1 || RD_LAT > 8) begin : g_chk_lat
      $error("vga_window_scanner: RD_LAT must be within 1..8");
   end

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic        win;
      logic        border;
      logic        fs;
`ifdef VGA_SCALE2X_EN
      logic        rd;
`endif
      logic [11:0] x;
      logic [11:0] y;
   } stage_t;

   localparam stage_t C_ST_RST = '{hs: 1'b1, vs: 1'b1, default: '0};

   logic [11:0]       r_h_cnt;
   logic [11:0]       r_v_cnt;
   logic [ADDR_W-1:0] r_ptr;
   stage_t            r_pipe [0:RD_LAT];

   logic              w_de0;
   logic              w_in_win0;
   logic              w_rd0;
   logic              w_frame_end;
   stage_t            w_st0;
   stage_t            w_out;
   logic [7:0]        w_pix;
   logic [7:0]        w_grey;

   // Stage 0: raster counters, (0,0) is the first active pixel
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_h_cnt == L_H_LAST) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == L_V_LAST) ? 12'd0 : r_v_cnt + 12'd1;
      end else begin
         r_h_cnt <= r_h_cnt + 12'd1;
      end
   end

   assign w_de0       = (r_h_cnt < L_HA) && (r_v_cnt < L_VA);
   assign w_in_win0   = (r_h_cnt >= L_WX0) && (r_h_cnt < L_WX1) &&
                        (r_v_cnt >= L_WY0) && (r_v_cnt < L_WY1);
   assign w_frame_end = (r_h_cnt == L_H_LAST) && (r_v_cnt == L_V_LAST);

`ifdef VGA_SCALE2X_EN
   localparam logic [11:0] L_WX_LAST = 12'(WIN_X + WIN_FW - 1);

   logic              w_col_odd;
   logic              w_row_odd;
   logic              w_row_first;
   logic              w_row_rewind;
   logic [ADDR_W-1:0] r_row_start;

   // Parity relative to the window origin avoids a subtractor
   assign w_col_odd    = r_h_cnt[0] ^ L_WX0[0];
   assign w_row_odd    = r_v_cnt[0] ^ L_WY0[0];
   assign w_rd0        = w_in_win0 && !w_col_odd;
   assign w_row_first  = w_in_win0 && !w_row_odd && (r_h_cnt == L_WX0);
   assign w_row_rewind = w_in_win0 && !w_row_odd && (r_h_cnt == L_WX_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_row_start <= L_BASE;
      end else if (w_row_first) begin
         r_row_start <= r_ptr;
      end
   end
`else
   assign w_rd0 = w_in_win0;
`endif

   // Stage 1: read issue and incremental address pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         r_ptr    <= L_BASE;
      end else begin
         mem_rd   <= w_rd0;
         mem_addr <= w_rd0 ? r_ptr : '0;
         if (w_frame_end) begin
            r_ptr <= L_BASE;
`ifdef VGA_SCALE2X_EN
         end else if (w_row_rewind) begin
            r_ptr <= r_row_start;
`endif
         end else if (w_rd0) begin
            r_ptr <= r_ptr + 1'b1;
         end
      end
   end

   always_comb begin
      w_st0        = '0;
      w_st0.hs     = !((r_h_cnt >= L_HS_BEG) && (r_h_cnt < L_HS_END));
      w_st0.vs     = !((r_v_cnt >= L_VS_BEG) && (r_v_cnt < L_VS_END));
      w_st0.de     = w_de0;
      w_st0.win    = w_in_win0;
      w_st0.border = BORDER_EN && w_de0 &&
                     ((r_h_cnt == 12'd0) || (r_h_cnt == L_HA_LAST) ||
                      (r_v_cnt == 12'd0) || (r_v_cnt == L_VA_LAST));
      w_st0.fs     = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
`ifdef VGA_SCALE2X_EN
      w_st0.rd     = w_rd0;
`endif
      w_st0.x      = w_de0 ? r_h_cnt : 12'd0;
      w_st0.y      = w_de0 ? r_v_cnt : 12'd0;
   end

   // Stages 1..RD_LAT+1: delay line so the last stage meets the returning read data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i <= RD_LAT; i++) r_pipe[i] <= C_ST_RST;
      end else begin
         r_pipe[0] <= w_st0;
         for (int i = 1; i <= RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign w_out = r_pipe[RD_LAT];

`ifdef VGA_SCALE2X_EN
   logic [7:0] r_hold;

   // Odd window columns have no read of their own and repeat the last sample
   always_ff @(posedge clk) begin
      if (w_out.rd) r_hold <= mem_rdata;
   end

   assign w_pix = w_out.rd ? mem_rdata : r_hold;
`else
   assign w_pix = mem_rdata;
`endif

   always_comb begin
      w_grey = BG_COLOR;
      if (!w_out.de) begin
         w_grey = 8'h00;
      end else if (w_out.border) begin
         w_grey = 8'hFF;
      end else if (w_out.win) begin
         w_grey = w_pix;
      end
   end

   assign vga_hs      = w_out.hs;
   assign vga_vs      = w_out.vs;
   assign vga_de      = w_out.de;
   assign pix_x       = w_out.x;
   assign pix_y       = w_out.y;
   assign frame_start = w_out.fs;
   assign vga_r       = w_grey;
   assign vga_g       = w_grey;
   assign vga_b       = w_grey;

endmodule
